// File: rtl/program_sequencer_stk_if.sv
// Decoder-to-sequencer control bundle and sequencer status outputs.
// The master side is the instruction decoder; the slave side is the sequencer.
interface program_sequencer_stk_if #(
  parameter int PC_W        = 8,
  parameter int JA_W        = 4,
  parameter int STACK_DEPTH = 4,
  parameter int LC_W        = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic            sync_reset;
  logic            hold;
  logic            jmp;
  logic            jmp_nz;
  logic            dont_jmp;
  logic            call;
  logic            ret;
  logic [JA_W-1:0] jmp_addr;
  logic            loop_start;
  logic            loop_end;
  logic [LC_W-1:0] loop_cnt;
  logic [PC_W-1:0] pm_addr;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            stack_err;
  logic            loop_active;

  modport master (
    output sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
           loop_start, loop_end, loop_cnt,
    input  pm_addr, pc, sp, stack_err, loop_active
  );

  modport slave (
    input  sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
           loop_start, loop_end, loop_cnt,
    output pm_addr, pc, sp, stack_err, loop_active
  );
endinterface

// File: rtl/program_sequencer_stk.sv
// Program sequencer with return-address stack: selects the next program-memory
// address each cycle. Define SEQ_LOOP_EN to add a single-level zero-overhead loop.
module program_sequencer_stk #(
  parameter int PC_W        = 8,
  parameter int JA_W        = 4,
  parameter int STACK_DEPTH = 4,
  parameter int LC_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  program_sequencer_stk_if.slave  bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  pm_addr_next;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  top_entry;
  logic [SP_W-1:0]  sp_reg, sp_next;
  logic             stack_err_reg, stack_err_next;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic             stack_empty;
  logic             stack_full;
  logic             branch_src;
  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

  assign pc_inc      = pc_reg + PC_W'(1);
  assign target      = {bus.jmp_addr, {(PC_W-JA_W){1'b0}}};
  assign stack_empty = (sp_reg == '0);
  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign push_idx    = IDX_W'(sp_reg);
  assign top_idx     = IDX_W'(sp_reg - SP_W'(1));
  assign top_entry   = stack_mem[top_idx];
  // Any source that outranks the hardware loop redirect.
  assign branch_src  = bus.ret | bus.call | bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);

`ifdef SEQ_LOOP_EN
  logic [PC_W-1:0] loop_top_reg, loop_top_next;
  logic [LC_W-1:0] loop_count_reg, loop_count_next;
  logic            loop_active_reg, loop_active_next;
  logic            loop_taken;

  assign loop_taken = bus.loop_end & loop_active_reg & (loop_count_reg != '0);

  always_comb begin
    loop_top_next    = loop_top_reg;
    loop_count_next  = loop_count_reg;
    loop_active_next = loop_active_reg;
    if (bus.sync_reset) begin
      loop_count_next  = '0;
      loop_active_next = 1'b0;
    end else if (!bus.hold) begin
      if (bus.loop_start) begin
        loop_top_next    = pc_inc;
        loop_count_next  = bus.loop_cnt;
        loop_active_next = 1'b1;
      end else if (bus.loop_end && loop_active_reg) begin
        if (loop_count_reg == '0) begin
          loop_active_next = 1'b0;
        end else if (!branch_src) begin
          loop_count_next = loop_count_reg - LC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_top_reg    <= '0;
      loop_count_reg  <= '0;
      loop_active_reg <= 1'b0;
    end else begin
      loop_top_reg    <= loop_top_next;
      loop_count_reg  <= loop_count_next;
      loop_active_reg <= loop_active_next;
    end
  end

  assign bus.loop_active = loop_active_reg;
`else
  logic unused_loop_inputs;
  assign unused_loop_inputs = ^{bus.loop_start, bus.loop_end, bus.loop_cnt};
  assign bus.loop_active    = 1'b0;
`endif

  always_comb begin
    pm_addr_next   = pc_inc;
    sp_next        = sp_reg;
    stack_err_next = stack_err_reg;
    push_en        = 1'b0;
    if (!reset_n) begin
      pm_addr_next = '0;
    end else if (bus.sync_reset) begin
      pm_addr_next   = '0;
      sp_next        = '0;
      stack_err_next = 1'b0;
    end else if (bus.hold) begin
      pm_addr_next = pc_reg;
    end else if (bus.ret) begin
      // Underflow falls back to a plain increment.
      if (stack_empty) begin
        stack_err_next = 1'b1;
      end else begin
        pm_addr_next = top_entry;
        sp_next      = sp_reg - SP_W'(1);
      end
    end else if (bus.call) begin
      pm_addr_next = target;
      if (stack_full) begin
        stack_err_next = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_next = sp_reg + SP_W'(1);
      end
    end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
      pm_addr_next = target;
`ifdef SEQ_LOOP_EN
    end else if (loop_taken) begin
      pm_addr_next = loop_top_reg;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg        <= '0;
      sp_reg        <= '0;
      stack_err_reg <= 1'b0;
    end else begin
      pc_reg        <= pm_addr_next;
      sp_reg        <= sp_next;
      stack_err_reg <= stack_err_next;
    end
  end

  // Entries are left stale on pop; only sp tracks validity.
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk) begin
        if (push_en && (push_idx == IDX_W'(gi))) begin
          stack_mem[gi] <= pc_inc;
        end
      end
    end
  endgenerate

  assign bus.pm_addr   = pm_addr_next;
  assign bus.pc        = pc_reg;
  assign bus.sp        = sp_reg;
  assign bus.stack_err = stack_err_reg;
endmodule

// File: tb/tb_program_sequencer_stk.sv
// Directed bench for program_sequencer_stk: jumps, call/return, stack limits,
// hold, asynchronous reset and (when SEQ_LOOP_EN is defined) the hardware loop.
module tb_program_sequencer_stk;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  program_sequencer_stk_if #(.PC_W(8), .JA_W(4), .STACK_DEPTH(4), .LC_W(8)) bus ();

  program_sequencer_stk #(.PC_W(8), .JA_W(4), .STACK_DEPTH(4), .LC_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_ctrl();
    bus.sync_reset = 1'b0;
    bus.hold       = 1'b0;
    bus.jmp        = 1'b0;
    bus.jmp_nz     = 1'b0;
    bus.dont_jmp   = 1'b0;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
    bus.jmp_addr   = '0;
    bus.loop_start = 1'b0;
    bus.loop_end   = 1'b0;
    bus.loop_cnt   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [7:0] addr);
    clear_ctrl();
    bus.jmp      = 1'b1;
    bus.jmp_addr = addr[7:4];
    tick();
    bus.jmp = 1'b0;
    repeat (int'(addr[3:0])) tick();
  endtask

  task automatic do_sync_reset();
    clear_ctrl();
    bus.sync_reset = 1'b1;
    tick();
    bus.sync_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_ctrl();
    tick();
    tick();
    checks++; if (bus.pc !== 8'h00) begin failures++; $display("FAIL reset_pc actual=%h required=00", bus.pc); end
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL reset_sp actual=%0d required=0", bus.sp); end
    checks++; if (bus.stack_err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b required=0", bus.stack_err); end
    checks++; if (bus.loop_active !== 1'b0) begin failures++; $display("FAIL reset_loop_active actual=%b required=0", bus.loop_active); end
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL reset_pm_addr actual=%h required=00", bus.pm_addr); end
    $display("txn reset pc=%h sp=%0d", bus.pc, bus.sp);
    reset_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [7:0] exp;
    for (int i = 0; i <= 260; i++) begin
      exp = 8'(i);
      checks++; if (bus.pc !== exp) begin failures++; $display("FAIL free_run_pc[%0d] actual=%h required=%h", i, bus.pc, exp); end
      tick();
    end
    $display("txn free_run 261 cycles pc=%h", bus.pc);
  endtask

  task automatic test_jump();
    goto_pc(8'h05);
    checks++; if (bus.pc !== 8'h05) begin failures++; $display("FAIL jump_setup_pc actual=%h required=05", bus.pc); end
    bus.jmp = 1'b1; bus.jmp_addr = 4'h3;
    #1;
    checks++; if (bus.pm_addr !== 8'h30) begin failures++; $display("FAIL jmp_pm_addr actual=%h required=30", bus.pm_addr); end
    tick();
    bus.jmp = 1'b0;
    checks++; if (bus.pc !== 8'h30) begin failures++; $display("FAIL jmp_pc actual=%h required=30", bus.pc); end
    bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.jmp_addr = 4'h7;
    #1;
    checks++; if (bus.pm_addr !== 8'h31) begin failures++; $display("FAIL jmp_nz_suppressed actual=%h required=31", bus.pm_addr); end
    bus.dont_jmp = 1'b0;
    #1;
    checks++; if (bus.pm_addr !== 8'h70) begin failures++; $display("FAIL jmp_nz_taken actual=%h required=70", bus.pm_addr); end
    tick();
    checks++; if (bus.pc !== 8'h70) begin failures++; $display("FAIL jmp_nz_pc actual=%h required=70", bus.pc); end
    clear_ctrl();
    $display("txn jump pc=%h", bus.pc);
  endtask

  task automatic test_call_ret();
    do_sync_reset();
    goto_pc(8'h10);
    bus.call = 1'b1; bus.jmp_addr = 4'h4;
    #1;
    checks++; if (bus.pm_addr !== 8'h40) begin failures++; $display("FAIL call_pm_addr actual=%h required=40", bus.pm_addr); end
    tick();
    bus.call = 1'b0;
    checks++; if (bus.sp !== 3'd1) begin failures++; $display("FAIL call_sp actual=%0d required=1", bus.sp); end
    tick(); tick();
    checks++; if (bus.pc !== 8'h42) begin failures++; $display("FAIL call_body_pc actual=%h required=42", bus.pc); end
    bus.ret = 1'b1;
    #1;
    checks++; if (bus.pm_addr !== 8'h11) begin failures++; $display("FAIL ret_pm_addr actual=%h required=11", bus.pm_addr); end
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL ret_sp actual=%0d required=0", bus.sp); end
    checks++; if (bus.stack_err !== 1'b0) begin failures++; $display("FAIL ret_err actual=%b required=0", bus.stack_err); end
    $display("txn call_ret pc=%h sp=%0d", bus.pc, bus.sp);
  endtask

  task automatic test_back_to_back();
    // At pc 0x11: call 0x20 (push 0x12), then call 0x50 (push 0x21).
    bus.call = 1'b1; bus.jmp_addr = 4'h2;
    tick();
    bus.jmp_addr = 4'h5;
    tick();
    bus.call = 1'b0;
    checks++; if (bus.sp !== 3'd2) begin failures++; $display("FAIL b2b_sp actual=%0d required=2", bus.sp); end
    checks++; if (bus.pc !== 8'h50) begin failures++; $display("FAIL b2b_pc actual=%h required=50", bus.pc); end
    bus.call = 1'b1; bus.ret = 1'b1; bus.jmp_addr = 4'h9;
    #1;
    checks++; if (bus.pm_addr !== 8'h21) begin failures++; $display("FAIL call_ret_priority actual=%h required=21", bus.pm_addr); end
    tick();
    bus.call = 1'b0;
    checks++; if (bus.sp !== 3'd1) begin failures++; $display("FAIL call_ret_sp actual=%0d required=1", bus.sp); end
    #1;
    checks++; if (bus.pm_addr !== 8'h12) begin failures++; $display("FAIL b2b_ret2 actual=%h required=12", bus.pm_addr); end
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL b2b_final_sp actual=%0d required=0", bus.sp); end
    $display("txn back_to_back pc=%h sp=%0d", bus.pc, bus.sp);
  endtask

  task automatic test_stack_limits();
    logic [7:0] exp;
    logic [2:0] exp_sp;
    do_sync_reset();
    for (int k = 1; k <= 5; k++) begin
      bus.call = 1'b1; bus.jmp_addr = 4'(k);
      #1;
      exp = 8'(k * 16);
      checks++; if (bus.pm_addr !== exp) begin failures++; $display("FAIL ovf_call%0d_pm actual=%h required=%h", k, bus.pm_addr, exp); end
      tick();
      exp_sp = (k > 4) ? 3'd4 : 3'(k);
      checks++; if (bus.sp !== exp_sp) begin failures++; $display("FAIL ovf_call%0d_sp actual=%0d required=%0d", k, bus.sp, exp_sp); end
      checks++; if (bus.stack_err !== (k == 5)) begin failures++; $display("FAIL ovf_call%0d_err actual=%b required=%b", k, bus.stack_err, k == 5); end
    end
    bus.call = 1'b0;
    for (int j = 4; j >= 1; j--) begin
      bus.ret = 1'b1;
      #1;
      exp = 8'((j - 1) * 16 + 1);
      checks++; if (bus.pm_addr !== exp) begin failures++; $display("FAIL pop%0d_pm actual=%h required=%h", j, bus.pm_addr, exp); end
      tick();
    end
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL pop_all_sp actual=%0d required=0", bus.sp); end
    #1;
    checks++; if (bus.pm_addr !== 8'h02) begin failures++; $display("FAIL underflow_pm actual=%h required=02", bus.pm_addr); end
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL underflow_sp actual=%0d required=0", bus.sp); end
    checks++; if (bus.stack_err !== 1'b1) begin failures++; $display("FAIL underflow_err actual=%b required=1", bus.stack_err); end
    bus.sync_reset = 1'b1; bus.jmp = 1'b1;
    #1;
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL sync_reset_pm actual=%h required=00", bus.pm_addr); end
    tick();
    clear_ctrl();
    checks++; if (bus.stack_err !== 1'b0) begin failures++; $display("FAIL sync_reset_err actual=%b required=0", bus.stack_err); end
    checks++; if (bus.pc !== 8'h00) begin failures++; $display("FAIL sync_reset_pc actual=%h required=00", bus.pc); end
    $display("txn stack_limits pc=%h sp=%0d err=%b", bus.pc, bus.sp, bus.stack_err);
  endtask

  task automatic test_hold_and_async_reset();
    goto_pc(8'h20);
    bus.hold = 1'b1; bus.jmp = 1'b1; bus.jmp_addr = 4'h9;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.pm_addr !== 8'h20) begin failures++; $display("FAIL hold%0d_pm actual=%h required=20", c, bus.pm_addr); end
      tick();
      checks++; if (bus.pc !== 8'h20) begin failures++; $display("FAIL hold%0d_pc actual=%h required=20", c, bus.pc); end
    end
    clear_ctrl();
    bus.call = 1'b1; bus.jmp_addr = 4'h6;
    tick();
    checks++; if (bus.sp !== 3'd1) begin failures++; $display("FAIL pre_async_sp actual=%0d required=1", bus.sp); end
    bus.jmp_addr = 4'h7;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 8'h00) begin failures++; $display("FAIL async_reset_pc actual=%h required=00", bus.pc); end
    checks++; if (bus.sp !== 3'd0) begin failures++; $display("FAIL async_reset_sp actual=%0d required=0", bus.sp); end
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL async_reset_pm actual=%h required=00", bus.pm_addr); end
    clear_ctrl();
    tick();
    reset_n = 1'b1;
    $display("txn hold_async_reset pc=%h sp=%0d", bus.pc, bus.sp);
  endtask

  task automatic test_loop();
    logic [7:0] exp;
    do_sync_reset();
    goto_pc(8'h08);
    bus.loop_start = 1'b1; bus.loop_cnt = 8'd2;
    #1;
    checks++; if (bus.pm_addr !== 8'h09) begin failures++; $display("FAIL loop_start_pm actual=%h required=09", bus.pm_addr); end
    tick();
    bus.loop_start = 1'b0;
`ifdef SEQ_LOOP_EN
    checks++; if (bus.loop_active !== 1'b1) begin failures++; $display("FAIL loop_armed actual=%b required=1", bus.loop_active); end
    for (int it = 0; it < 3; it++) begin
      checks++; if (bus.pc !== 8'h09) begin failures++; $display("FAIL loop_it%0d_top actual=%h required=09", it, bus.pc); end
      tick();
      bus.loop_end = 1'b1;
      #1;
      exp = (it < 2) ? 8'h09 : 8'h0B;
      checks++; if (bus.pm_addr !== exp) begin failures++; $display("FAIL loop_it%0d_end_pm actual=%h required=%h", it, bus.pm_addr, exp); end
      tick();
      bus.loop_end = 1'b0;
    end
    checks++; if (bus.pc !== 8'h0B) begin failures++; $display("FAIL loop_exit_pc actual=%h required=0B", bus.pc); end
    checks++; if (bus.loop_active !== 1'b0) begin failures++; $display("FAIL loop_exit_active actual=%b required=0", bus.loop_active); end
`else
    checks++; if (bus.loop_active !== 1'b0) begin failures++; $display("FAIL loop_disabled_active actual=%b required=0", bus.loop_active); end
    tick();
    bus.loop_end = 1'b1;
    #1;
    checks++; if (bus.pm_addr !== 8'h0B) begin failures++; $display("FAIL loop_disabled_end_pm actual=%h required=0B", bus.pm_addr); end
    tick();
    bus.loop_end = 1'b0;
    checks++; if (bus.pc !== 8'h0B) begin failures++; $display("FAIL loop_disabled_pc actual=%h required=0B", bus.pc); end
`endif
    clear_ctrl();
    $display("txn loop pc=%h loop_active=%b", bus.pc, bus.loop_active);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clear_ctrl();
    test_reset();
    test_free_run();
    test_jump();
    test_call_ret();
    test_back_to_back();
    test_stack_limits();
    test_hold_and_async_reset();
    test_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
